// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Holds one op in flight: grant/accept in IDLE, drive the ALU in ISSUE, hold the result in RESP.
module alu_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [5:0]       req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [5:0]       req1_fn,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_fn,
  input  logic [31:0]      alu_otp,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               rdy0_q, rdy0_d;
  logic               rdy1_q, rdy1_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [5:0]         alu_fn_q, alu_fn_d;
  logic               op_id_q, op_id_d;
  logic               op_err_q, op_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        sel_a, sel_b;
  logic [5:0]         sel_fn;
  logic               sel_legal;
  logic               accept;

  function automatic logic fn_legal(input logic [5:0] fn);
    case (fn)
      6'b000000, 6'b000001, 6'b000010,
      6'b000100, 6'b000101, 6'b000110,
      6'b001000, 6'b001001, 6'b001011: fn_legal = 1'b1;
      default:                         fn_legal = 1'b0;
    endcase
  endfunction

  // Operands of whichever requester currently holds the ready pulse
  always_comb begin
    sel_a     = rdy1_q ? req1_a  : req0_a;
    sel_b     = rdy1_q ? req1_b  : req0_b;
    sel_fn    = rdy1_q ? req1_fn : req0_fn;
    sel_legal = fn_legal(sel_fn);
    accept    = (rdy0_q && req0_valid) || (rdy1_q && req1_valid);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rdy0_d      = 1'b0;
    rdy1_d      = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fn_d    = alu_fn_q;
    op_id_d     = op_id_q;
    op_err_d    = op_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Illegal opcodes still issue, but with the ALU inputs zeroed
          alu_a_d  = sel_legal ? sel_a  : 32'd0;
          alu_b_d  = sel_legal ? sel_b  : 32'd0;
          alu_fn_d = sel_legal ? sel_fn : 6'd0;
          op_id_d  = rdy1_q;
          op_err_d = !sel_legal;
          state_d  = ISSUE;
        end else if (req0_valid && req1_valid) begin
          rdy1_d = ptr_q;
          rdy0_d = !ptr_q;
        end else begin
          rdy0_d = req0_valid;
          rdy1_d = req1_valid;
        end
      end
      ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_id_q;
        rsp_data_d  = op_err_q ? 32'd0 : alu_otp;
        rsp_zero_d  = op_err_q ? 1'b1  : alu_zero;
        rsp_ovf_d   = op_err_q ? 1'b0  : alu_ovf;
        rsp_err_d   = op_err_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = !ptr_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      rdy0_q      <= 1'b0;
      rdy1_q      <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_fn_q    <= 6'd0;
      op_id_q     <= 1'b0;
      op_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rdy0_q      <= rdy0_d;
      rdy1_q      <= rdy1_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fn_q    <= alu_fn_d;
      op_id_q     <= op_id_d;
      op_err_q    <= op_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req0_ready = rdy0_q;
  assign req1_ready = rdy1_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fn     = alu_fn_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [5:0]       req0_fn, req1_fn;
  logic [31:0]      alu_a, alu_b, alu_otp;
  logic [5:0]       alu_fn;
  logic             alu_zero, alu_ovf;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_err, busy;
  logic [31:0]      rsp_data;
  logic [CNT_W-1:0] op_count;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU the arbiter drives
  always_comb begin
    alu_otp = 32'd0;
    alu_ovf = 1'b0;
    case (alu_fn)
      6'h00: begin
        alu_otp = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_otp[31] != alu_a[31]);
      end
      6'h01: begin
        alu_otp = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_otp[31] != alu_a[31]);
      end
      6'h02: alu_otp = alu_a * alu_b;
      6'h04: alu_otp = alu_a & alu_b;
      6'h05: alu_otp = alu_a | alu_b;
      6'h06: alu_otp = alu_a ^ alu_b;
      6'h08: alu_otp = alu_a << alu_b[4:0];
      6'h09: alu_otp = alu_a >> alu_b[4:0];
      6'h0B: alu_otp = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: ;
    endcase
    alu_zero = (alu_otp == 32'd0);
  end

  typedef struct {
    logic        rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [5:0]  e_fn;
    logic [31:0] e_alua;
    logic [31:0] e_data;
    logic        e_zero;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t vecs[12];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Raise valid, wait for the ready pulse, let it be accepted; returns in the ISSUE cycle
  task automatic start_op(input logic rq, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] fn, output bit ok);
    int n;
    ok = 1'b1;
    if (rq) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fn = fn; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fn = fn; end
    n = 0;
    while (!(rq ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    chk("other_ready_low", 32'(rq ? req0_ready : req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    bit ok;
    start_op(v.rq, v.a, v.b, v.fn, ok);
    if (!ok) return;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_alu_fn", 32'(alu_fn), 32'(v.e_fn));
    chk("issue_alu_a", alu_a, v.e_alua);
    chk("issue_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, v.e_data);
    chk("rsp_zero", 32'(rsp_zero), 32'(v.e_zero));
    chk("rsp_ovf", 32'(rsp_ovf), 32'(v.e_ovf));
    chk("rsp_err", 32'(rsp_err), 32'(v.e_err));
    chk("rsp_id", 32'(rsp_id), 32'(v.rq));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("alu_fn_hold", 32'(alu_fn), 32'(v.e_fn));
  endtask

  initial begin
    bit ok;
    int gseq[4];
    int g;
    int rsp_by[2];
    bit drop;

    vecs[0]  = '{1'b0, 32'd5,         32'd3,         6'h01, 6'h01, 32'd5,         32'd2,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h7FFFFFFF,  32'd1,         6'h00, 6'h00, 32'h7FFFFFFF,  32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'hAAAA5555,  32'hAAAA5555,  6'h06, 6'h06, 32'hAAAA5555,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'd12,        32'd34,        6'h03, 6'h00, 32'd0,         32'd0,         1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  6'h04, 6'h04, 32'hF0F0F0F0,  32'h00F000F0,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'd1,         32'd2,         6'h05, 6'h05, 32'd1,         32'd3,         1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'd1,         32'd4,         6'h08, 6'h08, 32'd1,         32'h10,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h80000000,  32'd31,        6'h09, 6'h09, 32'h80000000,  32'd1,         1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         6'h0B, 6'h0B, 32'hFFFFFFFF,  32'd1,         1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'd6,         32'd7,         6'h02, 6'h02, 32'd6,         32'd42,        1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'hDEADBEEF,  32'd1,         6'h3F, 6'h00, 32'd0,         32'd0,         1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 32'd0,         32'd0,         6'h00, 6'h00, 32'd0,         32'd0,         1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_fn = '0;
    req1_a = '0; req1_b = '0; req1_fn = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_valid_ready", 32'({req0_ready, req1_ready}), 32'd0);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Backpressure: response held for five cycles while both requesters wait
    start_op(1'b0, 32'd9, 32'd4, 6'h00, ok);
    if (ok) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_data", rsp_data, 32'd13);
        chk("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_cnt++;
      chk("bp_done_valid", 32'(rsp_valid), 32'd0);
      chk("bp_done_busy", 32'(busy), 32'd0);
      chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
    end

    // Reset while a response is pending (pointer currently favours requester 1)
    start_op(1'b1, 32'd1, 32'd1, 6'h00, ok);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_count", 32'(op_count), 32'd0);
    chk("async_rst_alu_fn", 32'(alu_fn), 32'd0);
    chk("async_rst_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;

    // Contention: both valid continuously, response always accepted
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_fn = 6'h00;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd1; req1_fn = 6'h01;
    rsp_ready = 1'b1;
    g = 0; drop = 1'b0;
    rsp_by[0] = 0; rsp_by[1] = 0;
    for (int i = 0; i < 4; i++) gseq[i] = -1;
    for (int c = 0; c < 40; c++) begin
      if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (g < 4 && (req0_ready || req1_ready)) begin
        gseq[g] = int'(req1_ready);
        g++;
        if (g == 4) drop = 1'b1;
      end
      if (rsp_valid) rsp_by[rsp_id]++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("grant_count", 32'(g), 32'd4);
    chk("grant0", 32'(gseq[0]), 32'd0);
    chk("grant1", 32'(gseq[1]), 32'd1);
    chk("grant2", 32'(gseq[2]), 32'd0);
    chk("grant3", 32'(gseq[3]), 32'd1);
    chk("rsp_by_req0", 32'(rsp_by[0]), 32'd2);
    chk("rsp_by_req1", 32'(rsp_by[1]), 32'd2);
    chk("contention_count", 32'(op_count), 32'd4);
    chk("contention_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid/req1_valid  input  1  requester 0/1 has an op pending.
REQ-006 req0_ready/req1_ready  output  1  op accepted this cycle (valid&&ready).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-008 req0_fn, req1_fn  input  6  opcode, alufn encoding.
REQ-009 alu_a, alu_b  output  32 and alu_fn  output  6  registered drive to the shared combinational ALU.
REQ-010 alu_otp  input  32, alu_zero  input  1, alu_ovf  input  1  ALU results.
REQ-011 rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-012 rsp_id  output  1  requester that owns the response.
REQ-013 rsp_data  output  32, rsp_zero  output  1, rsp_ovf  output  1, rsp_err  output  1  result fields.
REQ-014 busy  output  1  high in any state but IDLE; op_count  output  CNT_W  completed responses, saturating.

Function
REQ-015 Legal opcodes SHALL be: 000000 ADD, 000001 SUB, 000010 MUL, 000100 AND, 000101 OR, 000110 XOR, 001000 SLL, 001001 SRL, 001011 SLT; all others are illegal.
REQ-016 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-017 IDLE: when either valid is high, the arbiter SHALL grant exactly one requester, pulse its ready for one cycle, latch a/b/fn/id, and go to ISSUE; with no valid, stay IDLE and keep both readies low.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester whose priority pointer is set; the pointer moves to the other requester when a response completes.
REQ-019 No ready SHALL be asserted outside IDLE; one op is in flight at most.
REQ-020 ISSUE (one cycle): alu_a/alu_b/alu_fn SHALL hold the latched values; at cycle end the block captures alu_otp/alu_zero/alu_ovf into the rsp registers and goes to RESP.
REQ-021 An illegal opcode SHALL still pass through ISSUE, with alu_fn driven 000000 and alu_a/alu_b driven 0; it produces rsp_data=0, rsp_zero=1, rsp_ovf=0, rsp_err=1.
REQ-022 RESP: rsp_valid SHALL be high and all rsp fields stable until rsp_valid&&rsp_ready; then go to IDLE, increment op_count unless it is all-ones, and flip the pointer.
REQ-023 Latency: accept at edge N SHALL give rsp_valid high after edge N+2; with rsp_ready held high, the next accept occurs at edge N+4 at the earliest.
REQ-024 alu_* outputs SHALL be registered and hold their last value in RESP and IDLE.
REQ-025 A requester deasserting valid without a handshake SHALL not be granted; fields are sampled only at acceptance.

Reset
REQ-026 When rst_n goes low, the block SHALL immediately force: state IDLE, pointer to requester 0, all ready/rsp_valid/busy 0, alu_*/rsp_* 0, op_count 0.
REQ-027 A reset in ISSUE or RESP SHALL abort the op with no response, no count increment, and no ready after release until the first IDLE edge with valid.

Verification
REQ-028 Single op: req0 a=5, b=3, fn=000001 -> req0_ready one cycle, rsp_valid two edges later with rsp_data=2, zero=0, ovf=0, err=0, id=0, op_count=1.
REQ-029 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each requester gets 2 of 4 responses.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp fields constant, both readies low, busy=1; rsp_ready=1 -> handshake, then IDLE.
REQ-031 Illegal op: req1 fn=000011 -> rsp_err=1, rsp_data=0, rsp_zero=1, id=1.
REQ-032 Overflow: ADD a=7FFFFFFF, b=1, with the ALU model returning otp=80000000, ovf=1 -> rsp_ovf=1, rsp_data=80000000; XOR a=b=AAAA5555 -> rsp_zero=1.
REQ-033 Reset mid-RESP -> rsp_valid drops asynchronously, op_count=0, pointer=0; after release both valid -> requester 0 granted first.
